// File: rtl/adc_cv_capture_pkg.sv
// Shared CV-capture types: bank geometry, FSM encoding, word extractor.
// Used by adc_cv_capture and, when CV_SMOOTH_EN is defined, cv_smoother.
package addatone_cv_pkg;
  localparam int NUM_CV   = 5;
  localparam int CV_WIDTH = 16;
  localparam int BUS_W    = NUM_CV * CV_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    UPDATE,
    DONE
  } cv_state_t;

  function automatic logic [CV_WIDTH-1:0] cv_word(
    input logic [BUS_W-1:0] bus,
    input int               k
  );
    return bus[k*CV_WIDTH +: CV_WIDTH];
  endfunction
endpackage

// File: rtl/adc_cv_capture_if.sv
// Bundle between the SPI CV receiver, the capture block and its consumers.
// master drives the receiver side; slave is the capture block.
interface adc_cv_capture_if;
  import addatone_cv_pkg::*;

  logic             i_Frame_Received;
  logic [BUS_W-1:0] i_CV_Data;
  logic [BUS_W-1:0] o_CV_Data;
  logic             o_CV_Valid;
  logic             o_Stale;
  logic [7:0]       o_Drop_Count;

  modport master (
    output i_Frame_Received,
    output i_CV_Data,
    input  o_CV_Data,
    input  o_CV_Valid,
    input  o_Stale,
    input  o_Drop_Count
  );

  modport slave (
    input  i_Frame_Received,
    input  i_CV_Data,
    output o_CV_Data,
    output o_CV_Valid,
    output o_Stale,
    output o_Drop_Count
  );
endinterface

// File: rtl/adc_cv_capture_smoother.sv
// cv_smoother: one-pole step y += (x - y) >>> SHIFT, or y = x when primed.
// Only built when CV_SMOOTH_EN is defined.
`ifdef CV_SMOOTH_EN
module cv_smoother
  import addatone_cv_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic [CV_WIDTH-1:0] x,
  input  logic [CV_WIDTH-1:0] y_old,
  input  logic                prime,
  output logic [CV_WIDTH-1:0] y_new
);
  logic signed [CV_WIDTH:0] diff;
  logic signed [CV_WIDTH:0] step;

  assign diff = $signed({1'b0, x}) - $signed({1'b0, y_old});
  assign step = diff >>> SHIFT;

  // step lies between 0 and x-y, so the wrap to 16 bits is exact
  assign y_new = prime ? x
               : CV_WIDTH'({1'b0, y_old} + $unsigned(step));
endmodule
`endif

// File: rtl/adc_cv_capture.sv
// Captures SPI CV frames into the i_Clock domain with stale/drop tracking.
// Define CV_SMOOTH_EN to run each word through a one-pole smoother.
module adc_cv_capture
  import addatone_cv_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
`ifdef CV_SMOOTH_EN
  parameter int SMOOTH_SHIFT  = 3,
`endif
  parameter int STALE_CYCLES  = 2000000
) (
  input  logic             i_Clock,
  input  logic             i_Reset_N,
  adc_cv_capture_if.slave  bus
);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int STW = $clog2(STALE_CYCLES + 1);
  localparam logic [STW-1:0] STALE_MAX = STW'(STALE_CYCLES);

  cv_state_t state;
  cv_state_t next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   synced_d;
  logic                   rise_q;
  logic [SCW-1:0]         settle_cnt;
  logic [BUS_W-1:0]       shadow;
  logic [BUS_W-1:0]       bank;
  logic [7:0]             drop;
  logic [STW-1:0]         stale_cnt;
  logic                   stale_q;
  logic                   upd_last;

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef CV_SMOOTH_EN
  localparam int IW = $clog2(NUM_CV);
  localparam logic [IW-1:0] LAST = IW'(NUM_CV - 1);

  logic [IW-1:0]       idx;
  logic                prime;
  logic [CV_WIDTH-1:0] x_w;
  logic [CV_WIDTH-1:0] y_w;
  logic [CV_WIDTH-1:0] y_new;

  assign x_w      = cv_word(shadow, int'(idx));
  assign y_w      = cv_word(bank, int'(idx));
  assign upd_last = (idx == LAST);

  cv_smoother #(
    .SHIFT (SMOOTH_SHIFT)
  ) u_smoother (
    .x     (x_w),
    .y_old (y_w),
    .prime (prime),
    .y_new (y_new)
  );
`else
  assign upd_last = 1'b1;
`endif

  // The data bus is never synchronised; only the flag crosses domains
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      sync_q   <= '0;
      synced_d <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.i_Frame_Received};
      synced_d <= synced;
      rise_q   <= synced & ~synced_d;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) state <= IDLE;
    else            state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (rise_q) next = SETTLE;
      SETTLE:  if (settle_cnt == '0) next = CHECK;
      CHECK:   next = synced ? UPDATE : IDLE;
      UPDATE:  if (upd_last) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      settle_cnt <= '0;
      shadow     <= '0;
      bank       <= '0;
      drop       <= '0;
`ifdef CV_SMOOTH_EN
      idx        <= '0;
      prime      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE:
          if (rise_q) settle_cnt <= SCW'(SETTLE_CYCLES - 1);
        SETTLE:
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        CHECK:
          if (synced)              shadow <= bus.i_CV_Data;
          else if (drop != 8'hFF)  drop   <= drop + 1'b1;
        UPDATE: begin
`ifdef CV_SMOOTH_EN
          bank[int'(idx)*CV_WIDTH +: CV_WIDTH] <= y_new;
          if (upd_last) begin
            idx   <= '0;
            prime <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
          end
`else
          bank <= shadow;
`endif
        end
        default: ;
      endcase
    end
  end

  // Count reaches STALE_MAX on the same edge that raises the flag
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      stale_cnt <= '0;
      stale_q   <= 1'b1;
    end else if (state == DONE) begin
      stale_cnt <= '0;
      stale_q   <= 1'b0;
    end else if (stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + 1'b1;
      if (stale_cnt == STALE_MAX - 1'b1) stale_q <= 1'b1;
    end
  end

  assign bus.o_CV_Data    = bank;
  assign bus.o_CV_Valid   = (state == DONE);
  assign bus.o_Stale      = stale_q;
  assign bus.o_Drop_Count = drop;
endmodule

// File: tb/tb_adc_cv_capture.sv
// Scoreboard bench for adc_cv_capture; covers both CV_SMOOTH_EN builds.
// Expected banks and valid cycles are queued by stimulus, popped by monitor.
module tb_adc_cv_capture;
  import addatone_cv_pkg::*;

`ifdef CV_SMOOTH_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 8;
`endif

  typedef struct {
    logic [BUS_W-1:0] data;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_vcyc = -1000;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_cv_capture_if cv_if ();

  adc_cv_capture #(
    .STALE_CYCLES (100)
  ) dut (
    .i_Clock   (clk),
    .i_Reset_N (rst_n),
    .bus       (cv_if)
  );

  task automatic check(input string name,
                       input logic [BUS_W-1:0] got,
                       input logic [BUS_W-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic logic [BUS_W-1:0] fill(input logic [15:0] w);
    return {NUM_CV{w}};
  endfunction

  always @(negedge clk) begin
    if (rst_n && cv_if.o_CV_Valid === 1'b1) begin
      last_vcyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bank", cv_if.o_CV_Data, e.data);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [BUS_W-1:0] d, input int hold,
                      input logic expect_it, input logic [BUS_W-1:0] want);
    @(negedge clk);
    cv_if.i_CV_Data = d;
    cv_if.i_Frame_Received = 1'b1;
    if (expect_it) sb.push_back('{want, cyc + LAT});
    repeat (hold) @(negedge clk);
    cv_if.i_Frame_Received = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [BUS_W-1:0] frame_a;
  int               target;
  int               c0;

  initial begin
    cv_if.i_Frame_Received = 1'b0;
    cv_if.i_CV_Data = '0;
    frame_a = {16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h0000};

    idle(3);
    check("rst_bank", cv_if.o_CV_Data, '0);
    check("rst_valid", cv_if.o_CV_Valid, 0);
    check("rst_stale", cv_if.o_Stale, 1);
    check("rst_drop", cv_if.o_Drop_Count, 0);
    rst_n = 1'b1;
    idle(150);
    check("quiet_stale", cv_if.o_Stale, 1);
    check("quiet_bank", cv_if.o_CV_Data, '0);

    send(frame_a, 20, 1'b1, frame_a);
    target = last_vcyc + 100;
    for (int k = 0; k < 300 && cyc < target; k++) @(negedge clk);
    check("stale_before", cv_if.o_Stale, 0);
    @(negedge clk);
    check("stale_after", cv_if.o_Stale, 1);

    send(fill(16'hAAAA), 1, 1'b0, '0);
    idle(12);
    check("drop_one", cv_if.o_Drop_Count, 1);
    check("drop_bank", cv_if.o_CV_Data, frame_a);
    for (int i = 0; i < 299; i++) begin
      send(fill(16'h5555), 1, 1'b0, '0);
      idle(9);
    end
    check("drop_sat", cv_if.o_Drop_Count, 255);
    check("drop_sat_bank", cv_if.o_CV_Data, frame_a);

    @(negedge clk);
    cv_if.i_CV_Data = fill(16'h4444);
    cv_if.i_Frame_Received = 1'b1;
    idle(7);
    rst_n = 1'b0;
    #1;
    check("midrst_bank", cv_if.o_CV_Data, '0);
    check("midrst_stale", cv_if.o_Stale, 1);
    check("midrst_valid", cv_if.o_CV_Valid, 0);
    cv_if.i_Frame_Received = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(15);
    check("midrst_drop", cv_if.o_Drop_Count, 0);
    check("midrst_bank2", cv_if.o_CV_Data, '0);

    send(fill(16'h0800), 20, 1'b1, fill(16'h0800));
    idle(10);
`ifdef CV_SMOOTH_EN
    send(fill(16'h1000), 20, 1'b1, fill(16'h0900));
    idle(10);
    send(fill(16'h0000), 20, 1'b1, fill(16'h07E0));
`else
    send(fill(16'h1000), 20, 1'b1, fill(16'h1000));
    idle(10);
    send(fill(16'h0000), 20, 1'b1, fill(16'h0000));
`endif
    idle(10);

    // second rise lands in UPDATE only when smoothing lengthens it
    @(negedge clk);
    cv_if.i_CV_Data = fill(16'h07E0);
    cv_if.i_Frame_Received = 1'b1;
    c0 = cyc;
    sb.push_back('{fill(16'h07E0), c0 + LAT});
    idle(5);
    cv_if.i_Frame_Received = 1'b0;
    idle(2);
    cv_if.i_CV_Data = fill(16'hFFFF);
    cv_if.i_Frame_Received = 1'b1;
`ifndef CV_SMOOTH_EN
    sb.push_back('{fill(16'hFFFF), cyc + LAT});
`endif
    idle(20);
    cv_if.i_Frame_Received = 1'b0;
    idle(10);

`ifdef CV_SMOOTH_EN
    send(fill(16'h08E0), 20, 1'b1, fill(16'h0800));
`else
    send(fill(16'h08E0), 20, 1'b1, fill(16'h08E0));
`endif
    idle(15);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
